// File: rtl/mem_req_ctrl_if.sv
// Pipeline request/response and tagged memory bus signals of the memory request controller.
// The slave modport is the controller; the master modport is the pipeline and memory side.
interface mem_req_ctrl_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  logic [31:0] proc2mem_addr;
  logic [31:0] proc2mem_data;
  logic [1:0]  proc2mem_command;
  logic [3:0]  mem2proc_response;
  logic [31:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
    output proc2mem_addr, proc2mem_data, proc2mem_command
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
    input  proc2mem_addr, proc2mem_data, proc2mem_command
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// Single-outstanding load/store initiator for the tagged memory bus: retries rejected
// commands, waits for the matching load tag and returns a one-cycle completion pulse.
module mem_req_ctrl #(
  parameter int unsigned MAX_RETRY = 15,
  parameter int unsigned TIMEOUT   = 255
) (
  input logic           clk,
  input logic           rst,
  mem_req_ctrl_if.slave bus_io
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StErr} state_e;

  localparam logic [3:0] RetryMax   = 4'(MAX_RETRY);
  localparam logic [7:0] TimeoutMax = 8'(TIMEOUT);
  localparam logic [1:0] CmdNone    = 2'b00;
  localparam logic [1:0] CmdLoad    = 2'b01;
  localparam logic [1:0] CmdStore   = 2'b10;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [3:0]  tag_q, tag_d;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  timeout_q, timeout_d;
  logic [31:0] rdata_q, rdata_d;

  logic [3:0]  retry_inc;
  logic [7:0]  timeout_inc;
  logic        rejected;
  logic        tag_hit;

  // Both counters saturate at their compare value.
  assign retry_inc   = (retry_q == RetryMax) ? retry_q : retry_q + 4'd1;
  assign timeout_inc = (timeout_q == TimeoutMax) ? timeout_q : timeout_q + 8'd1;
  assign rejected    = (bus_io.mem2proc_response == 4'd0);
  // Tag 0 never matches, so traffic arriving after an abort or reset is ignored.
  assign tag_hit     = (bus_io.mem2proc_tag != 4'd0) && (bus_io.mem2proc_tag == tag_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus_io.req_valid) state_d = StReq;
      StReq: begin
        if (rejected) begin
          if (retry_inc == RetryMax) state_d = StErr;
        end else begin
          state_d = write_q ? StDone : StWait;
        end
      end
      StWait: begin
        if (tag_hit) begin
          state_d = StDone;
        end else if (timeout_inc == TimeoutMax) begin
          state_d = StErr;
        end
      end
      StDone, StErr: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    tag_d     = tag_q;
    retry_d   = retry_q;
    timeout_d = timeout_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      StIdle: begin
        tag_d = 4'd0;
        if (bus_io.req_valid) begin
          addr_d  = bus_io.req_addr;
          wdata_d = bus_io.req_wdata;
          write_d = bus_io.req_write;
          retry_d = 4'd0;
          rdata_d = 32'd0;
        end
      end
      StReq: begin
        if (rejected) begin
          retry_d = retry_inc;
        end else if (write_q) begin
          rdata_d = 32'd0;
        end else begin
          tag_d     = bus_io.mem2proc_response;
          timeout_d = 8'd0;
        end
      end
      StWait: begin
        if (tag_hit) begin
          rdata_d = bus_io.mem2proc_data;
        end else begin
          timeout_d = timeout_inc;
        end
      end
      StDone, StErr: tag_d = 4'd0;
      default: tag_d = 4'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      write_q   <= 1'b0;
      tag_q     <= 4'd0;
      retry_q   <= 4'd0;
      timeout_q <= 8'd0;
      rdata_q   <= 32'd0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      tag_q     <= tag_d;
      retry_q   <= retry_d;
      timeout_q <= timeout_d;
      rdata_q   <= rdata_d;
    end
  end

  // Outputs decode straight from state so reset forces command NONE without waiting for a clock.
  always_comb begin
    bus_io.req_ready        = (state_q == StIdle);
    bus_io.busy             = (state_q != StIdle);
    bus_io.resp_valid       = (state_q == StDone) || (state_q == StErr);
    bus_io.resp_err         = (state_q == StErr);
    bus_io.resp_rdata       = (state_q == StDone) ? rdata_q : 32'd0;
    bus_io.proc2mem_addr    = addr_q;
    bus_io.proc2mem_data    = wdata_q;
    bus_io.proc2mem_command = CmdNone;
    if (state_q == StReq) bus_io.proc2mem_command = write_q ? CmdStore : CmdLoad;
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Randomized bench for mem_req_ctrl: each transaction's timeline (issue cycles, completion
// cycle, result) is predicted from retry/latency arithmetic and checked cycle by cycle.
module tb_mem_req_ctrl;

  localparam int MaxRetry = 15;
  localparam int Timeout  = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_req_ctrl_if bus ();

  mem_req_ctrl #(
    .MAX_RETRY(MaxRetry),
    .TIMEOUT  (Timeout)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] other_tag(input logic [3:0] tag);
    int r;
    r = ((int'(tag) + int'($urandom_range(0, 13))) % 15) + 1;
    return 4'(r);
  endfunction

  // Precondition: called just after a clock edge, in a cycle where the DUT is idle.
  // rej: rejected issues before acceptance; match_j: WAIT cycle index carrying the tag (-1: never).
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int rej, input logic [3:0] tag, input int match_j,
                         input logic [31:0] ldata, input logic noise);
    int          nreq;
    int          exp_c;
    logic        exp_err;
    logic [31:0] exp_rdata;
    if (rej >= MaxRetry) begin
      nreq = MaxRetry; exp_c = MaxRetry + 1; exp_err = 1'b1; exp_rdata = 32'd0;
    end else begin
      nreq = rej + 1;
      if (wr) begin
        exp_c = rej + 2; exp_err = 1'b0; exp_rdata = 32'd0;
      end else if (match_j >= 0 && match_j < Timeout) begin
        exp_c = rej + 3 + match_j; exp_err = 1'b0; exp_rdata = ldata;
      end else begin
        exp_c = rej + 2 + Timeout; exp_err = 1'b1; exp_rdata = 32'd0;
      end
    end

    bus.req_valid         = 1'b1;
    bus.req_write         = wr;
    bus.req_addr          = addr;
    bus.req_wdata         = wdata;
    bus.mem2proc_response = 4'd0;
    bus.mem2proc_tag      = 4'd0;
    bus.mem2proc_data     = $urandom;
    @(negedge clk);
    check_eq("idle_ready", 32'(bus.req_ready), 32'd1);
    check_eq("idle_busy", 32'(bus.busy), 32'd0);

    for (int c = 1; c <= exp_c; c++) begin
      @(posedge clk);
      #1;
      // Request inputs are junk while busy and must be ignored.
      bus.req_valid = 1'($urandom);
      bus.req_write = 1'($urandom);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      bus.mem2proc_response = (rej < MaxRetry && c == rej + 1) ? tag : 4'd0;
      if (!wr && rej < MaxRetry && match_j >= 0 && c == rej + 2 + match_j) begin
        bus.mem2proc_tag  = tag;
        bus.mem2proc_data = ldata;
      end else if (noise && $urandom_range(0, 2) == 0) begin
        bus.mem2proc_tag  = other_tag(tag);
        bus.mem2proc_data = $urandom;
      end else begin
        bus.mem2proc_tag  = 4'd0;
        bus.mem2proc_data = $urandom;
      end
      @(negedge clk);
      check_eq("busy", 32'(bus.busy), 32'd1);
      check_eq("req_ready", 32'(bus.req_ready), 32'd0);
      if (c <= nreq) begin
        check_eq("cmd_issue", 32'(bus.proc2mem_command), wr ? 32'd2 : 32'd1);
        check_eq("cmd_addr", bus.proc2mem_addr, addr);
        check_eq("cmd_data", bus.proc2mem_data, wdata);
      end else begin
        check_eq("cmd_none", 32'(bus.proc2mem_command), 32'd0);
      end
      if (c < exp_c) begin
        check_eq("resp_valid_low", 32'(bus.resp_valid), 32'd0);
      end else begin
        check_eq("resp_valid", 32'(bus.resp_valid), 32'd1);
        check_eq("resp_err", 32'(bus.resp_err), 32'(exp_err));
        check_eq("resp_rdata", bus.resp_rdata, exp_rdata);
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid         = 1'b0;
    bus.mem2proc_response = 4'd0;
    bus.mem2proc_tag      = 4'd0;
  endtask

  // Load accepted with tag 7, then reset asserted in WAIT; a late tag 7 must be ignored.
  task automatic reset_in_wait();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0000_0300;
    @(posedge clk);
    #1;
    bus.req_valid         = 1'b0;
    bus.mem2proc_response = 4'd7;
    @(negedge clk);
    check_eq("rst_pre_cmd", 32'(bus.proc2mem_command), 32'd1);
    @(posedge clk);
    #1;
    bus.mem2proc_response = 4'd0;
    @(negedge clk);
    check_eq("rst_wait_busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("rst_cmd_none", 32'(bus.proc2mem_command), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.mem2proc_tag  = 4'd7;
    bus.mem2proc_data = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("late_tag_resp", 32'(bus.resp_valid), 32'd0);
      check_eq("late_tag_busy", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.mem2proc_tag = 4'd0;
  endtask

  initial begin
    logic        wr;
    int          rej;
    int          mj;
    logic [3:0]  tag;

    rst                   = 1'b1;
    bus.req_valid         = 1'b0;
    bus.req_write         = 1'b0;
    bus.req_addr          = 32'd0;
    bus.req_wdata         = 32'd0;
    bus.mem2proc_response = 4'd0;
    bus.mem2proc_data     = 32'd0;
    bus.mem2proc_tag      = 4'd0;
    @(negedge clk);
    check_eq("rst_ready0", 32'(bus.req_ready), 32'd1);
    check_eq("rst_busy0", 32'(bus.busy), 32'd0);
    check_eq("rst_valid0", 32'(bus.resp_valid), 32'd0);
    check_eq("rst_err0", 32'(bus.resp_err), 32'd0);
    check_eq("rst_rdata0", bus.resp_rdata, 32'd0);
    check_eq("rst_cmd0", 32'(bus.proc2mem_command), 32'd0);
    check_eq("rst_addr0", bus.proc2mem_addr, 32'd0);
    check_eq("rst_data0", bus.proc2mem_data, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_txn(1'b1, 32'h100, 32'hDEAD_BEEF, 0, 4'd3, -1, 32'd0, 1'b0);
    run_txn(1'b0, 32'h200, 32'd0, 0, 4'd5, 3, 32'h1234_5678, 1'b0);
    run_txn(1'b0, 32'h204, 32'd0, 3, 4'd2, 1, 32'h0BAD_F00D, 1'b0);
    run_txn(1'b0, 32'h208, 32'd0, MaxRetry, 4'd2, 1, 32'h1111_1111, 1'b0);
    run_txn(1'b0, 32'h300, 32'd0, 0, 4'd7, 5, 32'h0000_BBBB, 1'b1);
    run_txn(1'b0, 32'h304, 32'd0, 1, 4'd7, -1, 32'h0, 1'b1);
    run_txn(1'b0, 32'h308, 32'd0, 0, 4'd9, Timeout - 1, 32'h5A5A_A5A5, 1'b1);
    reset_in_wait();
    run_txn(1'b0, 32'h400, 32'd0, 0, 4'd7, 2, 32'h7777_0007, 1'b0);
    run_txn(1'b0, 32'h404, 32'd0, 0, 4'd1, 0, 32'h0102_0304, 1'b0);

    for (int n = 0; n < 30; n++) begin
      wr  = 1'($urandom);
      rej = ($urandom_range(0, 9) == 0) ? MaxRetry : int'($urandom_range(0, 4));
      tag = 4'($urandom_range(1, 15));
      case ($urandom_range(0, 15))
        0:       mj = -1;
        1:       mj = Timeout - 1;
        default: mj = int'($urandom_range(0, 12));
      endcase
      run_txn(wr, $urandom, $urandom, rej, tag, mj, $urandom, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
